// File: rtl/pb_entry_pkg.sv
// Shared types and constants for the pb_entry keypad front end.
package pb_entry_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned PB_DIGITS = 16;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_ENTRY  = 2'd1,
    S_LAUNCH = 2'd2,
    S_HOLD   = 2'd3
  } pb_state_e;

  // Index of the highest set digit bit; lower simultaneous presses lose.
  function automatic logic [NIBBLE_W-1:0] hi_index(input logic [PB_DIGITS-1:0] v);
    logic [NIBBLE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(PB_DIGITS); i++) begin
      if (v[i]) idx = NIBBLE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pb_sync_edge.sv
// Input conditioning: synchroniser chain, optional per-bit debounce, and a
// registered rising-edge detector producing one-cycle press events.
// Debounce is built only when PB_ENTRY_DEBOUNCE_EN is defined.
module pb_sync_edge #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("pb_sync_edge: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_lvl;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_d;

  // Metastability chain for the raw asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PB_ENTRY_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt [WIDTH];
  logic [WIDTH-1:0] db_level;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level <= '0;
      for (int b = 0; b < int'(WIDTH); b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < int'(WIDTH); b++) begin
        if (sync_lvl[b] == db_level[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == CNT_MAX) begin
          db_level[b] <= sync_lvl[b];
          db_cnt[b]   <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  assign level = db_level;
`else
  assign level = sync_lvl;
`endif

  // Registered 0->1 detector: one event per press, none on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= '0;
      rise    <= '0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
    end
  end

endmodule

// File: rtl/pb_entry.sv
// Keypad entry stage: turns conditioned button events into a shifted hex
// word, commits it on load, and issues start requests gated by busy.
// Optional debounce in the conditioner: PB_ENTRY_DEBOUNCE_EN.
module pb_entry
  import pb_entry_pkg::*;
#(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic                           clk,
  input  logic                           nRST,
  input  logic [PB_DIGITS-1:0]           pb_in,
  input  logic                           load_btn,
  input  logic                           start_btn,
  input  logic                           busy,
  output logic [NIBBLE_W*DIGITS-1:0]     entry,
  output logic [$clog2(DIGITS+1)-1:0]    digit_count,
  output logic [NIBBLE_W*DIGITS-1:0]     data_out,
  output logic                           data_valid,
  output logic                           load_pulse,
  output logic                           start_pulse,
  output logic                           reject
);

  localparam int unsigned W  = NIBBLE_W * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned NB = PB_DIGITS + 2;

  logic [NB-1:0]        raw;
  logic [NB-1:0]        ev;
  logic [PB_DIGITS-1:0] dig_ev;
  logic                 dig_any;
  logic                 ld_ev;
  logic                 st_ev;
  logic [NIBBLE_W-1:0]  dig_idx;

  assign raw = {start_btn, load_btn, pb_in};

  pb_sync_edge #(
    .WIDTH           (NB),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_cond (
    .clk   (clk),
    .rst_n (nRST),
    .din   (raw),
    .rise  (ev)
  );

  assign dig_ev  = ev[PB_DIGITS-1:0];
  assign ld_ev   = ev[PB_DIGITS];
  assign st_ev   = ev[PB_DIGITS+1];
  assign dig_any = |dig_ev;
  assign dig_idx = hi_index(dig_ev);

  pb_state_e state_q;
  pb_state_e state_nxt;
  logic      acc_commit;
  logic      acc_start;
  logic      acc_digit;
  logic      rej;

  logic [W-1:0]  entry_nxt;
  logic [CW-1:0] count_nxt;
  logic [W-1:0]  data_nxt;
  logic          valid_nxt;
  logic          load_nxt;
  logic          start_nxt;
  logic          reject_nxt;

  // State register.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state_q <= S_EMPTY;
    else       state_q <= state_nxt;
  end

  // Next state and event arbitration: load > start > digit, requests gated by busy.
  always_comb begin
    state_nxt  = state_q;
    acc_commit = 1'b0;
    acc_start  = 1'b0;
    acc_digit  = 1'b0;
    rej        = 1'b0;
    case (state_q)
      S_EMPTY, S_ENTRY: begin
        if (ld_ev) begin
          if (state_q == S_ENTRY && !busy) begin
            acc_commit = 1'b1;
            state_nxt  = S_EMPTY;
          end else begin
            rej = 1'b1;
          end
          if (st_ev || dig_any) rej = 1'b1;
        end else if (st_ev) begin
          if (data_valid && !busy) begin
            acc_start = 1'b1;
            state_nxt = S_LAUNCH;
          end else begin
            rej = 1'b1;
          end
          if (dig_any) rej = 1'b1;
        end else if (dig_any) begin
          acc_digit = 1'b1;
          state_nxt = S_ENTRY;
        end
      end
      S_LAUNCH: begin
        rej = ld_ev | st_ev | dig_any;
        if (busy) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        rej = ld_ev | st_ev | dig_any;
        if (!busy) state_nxt = (digit_count == '0) ? S_EMPTY : S_ENTRY;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    entry_nxt  = entry;
    count_nxt  = digit_count;
    data_nxt   = data_out;
    valid_nxt  = data_valid;
    load_nxt   = 1'b0;
    start_nxt  = 1'b0;
    reject_nxt = rej;
    if (acc_commit) begin
      data_nxt  = entry;
      valid_nxt = 1'b1;
      load_nxt  = 1'b1;
      entry_nxt = '0;
      count_nxt = '0;
    end
    if (acc_start) start_nxt = 1'b1;
    if (acc_digit) begin
      entry_nxt = (entry << NIBBLE_W) | W'(dig_idx);
      if (digit_count != CW'(DIGITS)) count_nxt = digit_count + CW'(1);
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      entry       <= '0;
      digit_count <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      load_pulse  <= 1'b0;
      start_pulse <= 1'b0;
      reject      <= 1'b0;
    end else begin
      entry       <= entry_nxt;
      digit_count <= count_nxt;
      data_out    <= data_nxt;
      data_valid  <= valid_nxt;
      load_pulse  <= load_nxt;
      start_pulse <= start_nxt;
      reject      <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_pb_entry.sv
// Self-checking bench for pb_entry: directed scenarios followed by random
// button traffic, compared against a transaction-level model of the keypad.
module tb_pb_entry;

  localparam int DIGITS = 4;
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_HOLD = 2;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic [15:0] pb_in = '0;
  logic        load_btn = 1'b0;
  logic        start_btn = 1'b0;
  logic        busy = 1'b0;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic [15:0] data_out;
  logic        data_valid;
  logic        load_pulse;
  logic        start_pulse;
  logic        reject;

  pb_entry #(.DIGITS(DIGITS), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3)) dut (
    .clk         (clk),
    .nRST        (nRST),
    .pb_in       (pb_in),
    .load_btn    (load_btn),
    .start_btn   (start_btn),
    .busy        (busy),
    .entry       (entry),
    .digit_count (digit_count),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .load_pulse  (load_pulse),
    .start_pulse (start_pulse),
    .reject      (reject)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: the word as typed, the committed word, and engine phase.
  int m_entry, m_count, m_data, m_valid, phase;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int hi_idx(input logic [15:0] d);
    for (int i = 15; i >= 0; i--) if (d[i]) return i;
    return 0;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, ".entry"}, 32'(entry), 32'(m_entry));
    chk({tag, ".count"}, 32'(digit_count), 32'(m_count));
    chk({tag, ".data"},  32'(data_out), 32'(m_data));
    chk({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
  endtask

  task automatic model_reset();
    m_entry = 0; m_count = 0; m_data = 0; m_valid = 0; phase = P_IDLE;
  endtask

  task automatic do_reset();
    nRST = 1'b0; pb_in = '0; load_btn = 1'b0; start_btn = 1'b0; busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // One press of the given buttons (held 5 cycles), then settle; strobes counted.
  task automatic act(input logic [15:0] d, input bit l, input bit s, input string tag);
    int n_ld, n_st, n_rj;
    bit e_ld, e_st, e_rj, dg;
    dg = (d != 16'h0);
    e_ld = 0; e_st = 0; e_rj = 0;
    if (phase != P_IDLE) begin
      e_rj = dg | l | s;
    end else if (l) begin
      if (m_count > 0 && !busy) begin
        e_ld = 1; m_data = m_entry; m_valid = 1; m_entry = 0; m_count = 0;
      end else e_rj = 1;
      if (s || dg) e_rj = 1;
    end else if (s) begin
      if (m_valid != 0 && !busy) begin
        e_st = 1; phase = P_LAUNCH;
      end else e_rj = 1;
      if (dg) e_rj = 1;
    end else if (dg) begin
      m_entry = ((m_entry * 16) + hi_idx(d)) % 65536;
      m_count = (m_count < DIGITS) ? m_count + 1 : DIGITS;
    end
    n_ld = 0; n_st = 0; n_rj = 0;
    pb_in = d; load_btn = l; start_btn = s;
    for (int c = 0; c < 14; c++) begin
      if (c == 5) begin pb_in = '0; load_btn = 1'b0; start_btn = 1'b0; end
      @(posedge clk); #1;
      n_ld += int'(load_pulse);
      n_st += int'(start_pulse);
      n_rj += int'(reject);
    end
    chk({tag, ".load_pulse"},  32'(n_ld), 32'(e_ld));
    chk({tag, ".start_pulse"}, 32'(n_st), 32'(e_st));
    chk({tag, ".reject"},      32'(n_rj), 32'(e_rj));
    chk_state(tag);
  endtask

  task automatic set_busy(input bit b);
    busy = b;
    repeat (3) @(posedge clk);
    #1;
    if (b && phase == P_LAUNCH) phase = P_HOLD;
    else if (!b && phase == P_HOLD) phase = P_IDLE;
  endtask

  function automatic logic [15:0] one_hot(input int i);
    logic [15:0] v;
    v = 16'h1;
    return v << i;
  endfunction

  initial begin
    logic [15:0] d;
    int op;

    // Reset state.
    do_reset();
    chk("reset.entry", 32'(entry), 32'h0);
    chk("reset.count", 32'(digit_count), 32'h0);
    chk("reset.data",  32'(data_out), 32'h0);
    chk("reset.valid", 32'(data_valid), 32'h0);
    chk("reset.strobes", {29'h0, load_pulse, start_pulse, reject}, 32'h0);

    // Type 1,2,3,4.
    for (int i = 1; i <= 4; i++) act(one_hot(i), 1'b0, 1'b0, "type1234");
    chk("plan.entry1234", 32'(entry), 32'h1234);
    chk("plan.count4", 32'(digit_count), 32'd4);

    // Fifth digit drops the oldest nibble, then commit.
    act(one_hot(5), 1'b0, 1'b0, "type5");
    chk("plan.entry2345", 32'(entry), 32'h2345);
    chk("plan.count_sat", 32'(digit_count), 32'd4);
    act('0, 1'b1, 1'b0, "load");
    chk("plan.data2345", 32'(data_out), 32'h2345);
    chk("plan.valid", 32'(data_valid), 32'h1);
    chk("plan.entry_clr", 32'(entry), 32'h0);

    // Simultaneous digits 3 and 9: highest wins, no reject.
    act(one_hot(3) | one_hot(9), 1'b0, 1'b0, "dual3_9");
    chk("plan.dual_nibble", 32'(entry[3:0]), 32'h9);

    // Start, busy window with a rejected digit, busy release.
    act('0, 1'b0, 1'b1, "start");
    set_busy(1'b1);
    act(one_hot(7), 1'b0, 1'b0, "busy_digit");
    chk("plan.busy_entry", 32'(entry), 32'h9);
    set_busy(1'b0);
    act('0, 1'b1, 1'b0, "post_busy_load");

    // Load and start from reset are both rejected.
    do_reset();
    act('0, 1'b1, 1'b0, "empty_load");
    act('0, 1'b0, 1'b1, "empty_start");
    chk("plan.empty_valid", 32'(data_valid), 32'h0);

    // Priority combinations.
    act(one_hot(2), 1'b0, 1'b0, "pre_combo");
    act(one_hot(6), 1'b1, 1'b0, "load_digit");
    act(one_hot(1), 1'b0, 1'b0, "pre_ls");
    act('0, 1'b1, 1'b1, "load_start");

    // Reach S_LAUNCH with entry 0xAB, then reset asynchronously mid-cycle.
    act(one_hot(1), 1'b0, 1'b0, "launch_prep1");
    act('0, 1'b1, 1'b0, "launch_prep_load");
    act(one_hot(10), 1'b0, 1'b0, "launch_prepA");
    act(one_hot(11), 1'b0, 1'b0, "launch_prepB");
    act('0, 1'b0, 1'b1, "launch_start");
    chk("plan.entryAB", 32'(entry), 32'hAB);
    @(posedge clk);
    #3 nRST = 1'b0;
    #1;
    chk("midrst.entry", 32'(entry), 32'h0);
    chk("midrst.count", 32'(digit_count), 32'h0);
    chk("midrst.data",  32'(data_out), 32'h0);
    chk("midrst.valid", 32'(data_valid), 32'h0);
    chk("midrst.strobes", {29'h0, load_pulse, start_pulse, reject}, 32'h0);
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
    model_reset();
    act(one_hot(6), 1'b0, 1'b0, "after_midrst_digit");

`ifdef PB_ENTRY_DEBOUNCE_EN
    // A 2-cycle glitch is shorter than the debounce window.
    begin
      int n_rj;
      n_rj = 0;
      pb_in = one_hot(5);
      repeat (2) @(posedge clk);
      #1 pb_in = '0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk); #1;
        n_rj += int'(reject);
      end
      chk("glitch.reject", 32'(n_rj), 32'h0);
      chk_state("glitch");
    end
`endif

    // Random traffic.
    for (int k = 0; k < 60; k++) begin
      op = int'($urandom_range(0, 9));
      d  = one_hot(int'($urandom_range(0, 15)));
      case (op)
        0, 1, 2, 3, 4: act(d, 1'b0, 1'b0, "rnd_digit");
        5: act(d | one_hot(int'($urandom_range(0, 15))), 1'b0, 1'b0, "rnd_dual");
        6: act('0, 1'b1, 1'b0, "rnd_load");
        7: act('0, 1'b0, 1'b1, "rnd_start");
        8: begin
          case ($urandom_range(0, 2))
            0: act(d, 1'b1, 1'b0, "rnd_load_digit");
            1: act(d, 1'b0, 1'b1, "rnd_start_digit");
            default: act('0, 1'b1, 1'b1, "rnd_load_start");
          endcase
        end
        default: set_busy(~busy);
      endcase
    end
    set_busy(1'b0);
    act(one_hot(12), 1'b0, 1'b0, "final_digit");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
